// File: rtl/cpu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_core_if
// Description : Port-bus bundle between cpu_core and its I/O peripherals.
//               One outstanding request at a time; the slave may hold the
//               request for any number of cycles before acknowledging.
// Signals     : port_req   - request pending (master)
//               port_we    - 1 = write (OUT), 0 = read (IN) (master)
//               port_addr  - port address (master)
//               port_wdata - write data (master)
//               port_rdata - read data, valid with port_ack (slave)
//               port_ack   - completes the current request (slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_core_if #(
    parameter int WORD_SIZE = 16
) ();
    logic                 port_req;
    logic                 port_we;
    logic [WORD_SIZE-1:0] port_addr;
    logic [WORD_SIZE-1:0] port_wdata;
    logic [WORD_SIZE-1:0] port_rdata;
    logic                 port_ack;

    modport master (
        output port_req,
        output port_we,
        output port_addr,
        output port_wdata,
        input  port_rdata,
        input  port_ack
    );

    modport slave (
        input  port_req,
        input  port_we,
        input  port_addr,
        input  port_wdata,
        output port_rdata,
        output port_ack
    );
endinterface
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : cpu_core
// Description : Multi-cycle single-issue CPU with configurable data width and
//               register count. Fetches 16-bit instructions from an external
//               synchronous instruction memory and performs port I/O over a
//               req/ack bus that tolerates any number of wait states.
// Parameters  : WORD_SIZE (>=16) data/register width
//               REG_COUNT (1..16) implemented registers
//               PC_WIDTH  instruction-address width
// Ports       : clk        - system clock, rising edge
//               do_reset_n - synchronous active-low reset
//               run        - run gate, sampled in FETCH only
//               imem_addr  - instruction address (= pc)
//               imem_data  - instruction word, valid the cycle after address
//               port_bus   - port I/O bus (master side of cpu_core_if)
//               halted     - core is in HALTED
//               state      - FSM state for debug
//               opcode     - ir[15:12]
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_core #(
    parameter int WORD_SIZE = 16,
    parameter int REG_COUNT = 16,
    parameter int PC_WIDTH  = 8
) (
    input  wire logic                clk,
    input  wire logic                do_reset_n,
    input  wire logic                run,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  wire logic [15:0]         imem_data,
    cpu_core_if.master               port_bus,
    output logic                     halted,
    output logic [2:0]               state,
    output logic [3:0]               opcode
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_PORT   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_ADD    = 4'h0;
    localparam logic [3:0] c_OP_SUB    = 4'h1;
    localparam logic [3:0] c_OP_AND    = 4'h2;
    localparam logic [3:0] c_OP_OR     = 4'h3;
    localparam logic [3:0] c_OP_XOR    = 4'h4;
    localparam logic [3:0] c_OP_SHL    = 4'h5;
    localparam logic [3:0] c_OP_SHR    = 4'h6;
    localparam logic [3:0] c_OP_SLT    = 4'h7;
    localparam logic [3:0] c_OP_LOADLO = 4'h8;
    localparam logic [3:0] c_OP_LOADHI = 4'h9;
    localparam logic [3:0] c_OP_IN     = 4'hA;
    localparam logic [3:0] c_OP_OUT    = 4'hB;
    localparam logic [3:0] c_OP_JMP    = 4'hC;
    localparam logic [3:0] c_OP_BR     = 4'hD;
    localparam logic [3:0] c_OP_HALT   = 4'hE;

    localparam logic [4:0]          c_REG_LIMIT = 5'(REG_COUNT);
    localparam logic [PC_WIDTH-1:0] c_PC_ONE    = PC_WIDTH'(1);

    state_t               r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [15:0]          r_ir;
    // Full 16-entry array; entries at or above REG_COUNT are never written,
    // so they stay at their reset value and are pruned by synthesis.
    logic [WORD_SIZE-1:0] r_regs [16];
    logic                 r_port_req;
    logic                 r_port_we;
    logic [WORD_SIZE-1:0] r_port_addr;
    logic [WORD_SIZE-1:0] r_port_wdata;
    logic                 r_halted;

    // Instruction fields
    logic [3:0]           w_op;
    logic [3:0]           w_r1_idx;
    logic [3:0]           w_r2_idx;
    logic [3:0]           w_r3_idx;
    logic [7:0]           w_imm8;
    assign w_op     = r_ir[15:12];
    assign w_r1_idx = r_ir[11:8];
    assign w_r2_idx = r_ir[7:4];
    assign w_r3_idx = r_ir[3:0];
    assign w_imm8   = r_ir[7:0];

    // Register reads: indices beyond REG_COUNT read as zero.
    logic                 w_dst_ok;
    logic [WORD_SIZE-1:0] w_r1_val;
    logic [WORD_SIZE-1:0] w_r2_val;
    logic [WORD_SIZE-1:0] w_r3_val;
    assign w_dst_ok = ({1'b0, w_r1_idx} < c_REG_LIMIT);
    assign w_r1_val = w_dst_ok ? r_regs[w_r1_idx] : '0;
    assign w_r2_val = ({1'b0, w_r2_idx} < c_REG_LIMIT) ? r_regs[w_r2_idx] : '0;
    assign w_r3_val = ({1'b0, w_r3_idx} < c_REG_LIMIT) ? r_regs[w_r3_idx] : '0;

    // Sign-extended immediates for data and pc arithmetic.
    logic [WORD_SIZE-1:0] w_imm_word;
    logic [PC_WIDTH-1:0]  w_imm_pc;
    logic [PC_WIDTH-1:0]  w_pc_inc;
    logic [PC_WIDTH-1:0]  w_pc_rel;
    logic [WORD_SIZE-1:0] w_port_addr;
    assign w_imm_word  = WORD_SIZE'($signed(w_imm8));
    assign w_imm_pc    = PC_WIDTH'($signed(w_imm8));
    assign w_pc_inc    = r_pc + c_PC_ONE;
    assign w_pc_rel    = r_pc + w_imm_pc;
    assign w_port_addr = w_r2_val + {{(WORD_SIZE-4){1'b0}}, w_r3_idx};

    // ALU / load result; w_alu_wen marks opcodes that write r1 from EXEC.
    logic [WORD_SIZE-1:0] w_alu_result;
    logic                 w_alu_wen;
    always_comb begin
        w_alu_result = '0;
        w_alu_wen    = 1'b1;
        case (w_op)
            c_OP_ADD:    w_alu_result = w_r2_val + w_r3_val;
            c_OP_SUB:    w_alu_result = w_r2_val - w_r3_val;
            c_OP_AND:    w_alu_result = w_r2_val & w_r3_val;
            c_OP_OR:     w_alu_result = w_r2_val | w_r3_val;
            c_OP_XOR:    w_alu_result = w_r2_val ^ w_r3_val;
            c_OP_SHL:    w_alu_result = w_r2_val << w_r3_val[4:0];
            c_OP_SHR:    w_alu_result = w_r2_val >> w_r3_val[4:0];
            c_OP_SLT:    w_alu_result = {{(WORD_SIZE-1){1'b0}},
                                         ($signed(w_r2_val) < $signed(w_r3_val))};
            c_OP_LOADLO: w_alu_result = w_imm_word;
            c_OP_LOADHI: w_alu_result = {w_r1_val[WORD_SIZE-9:0], w_imm8};
            default:     w_alu_wen    = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!do_reset_n) begin
            r_state      <= S_FETCH;
            r_pc         <= '0;
            r_ir         <= 16'hF000;
            r_port_req   <= 1'b0;
            r_port_we    <= 1'b0;
            r_port_addr  <= '0;
            r_port_wdata <= '0;
            r_halted     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (run) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        c_OP_IN, c_OP_OUT: begin
                            // Port outputs are registered here and held
                            // unchanged for the whole PORT phase.
                            r_port_addr  <= w_port_addr;
                            r_port_we    <= (w_op == c_OP_OUT);
                            r_port_wdata <= w_r1_val;
                            r_port_req   <= 1'b1;
                            r_state      <= S_PORT;
                        end
                        c_OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALTED;
                        end
                        c_OP_JMP: begin
                            r_pc    <= w_pc_rel;
                            r_state <= S_FETCH;
                        end
                        c_OP_BR: begin
                            r_pc    <= (w_r1_val != '0) ? w_pc_rel : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        default: begin
                            if (w_alu_wen && w_dst_ok) begin
                                r_regs[w_r1_idx] <= w_alu_result;
                            end
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                    endcase
                end
                S_PORT: begin
                    if (port_bus.port_ack) begin
                        if (!r_port_we && w_dst_ok) begin
                            r_regs[w_r1_idx] <= port_bus.port_rdata;
                        end
                        r_port_req <= 1'b0;
                        r_pc       <= w_pc_inc;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_addr           = r_pc;
    assign port_bus.port_req   = r_port_req;
    assign port_bus.port_we    = r_port_we;
    assign port_bus.port_addr  = r_port_addr;
    assign port_bus.port_wdata = r_port_wdata;
    assign halted              = r_halted;
    assign state               = r_state;
    assign opcode              = r_ir[15:12];

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_core
// Description : Self-checking bench for cpu_core. A 16-bit core runs small
//               directed programs whose results are exported through OUT
//               instructions; a second 32-bit core with 8 registers covers
//               wide-constant construction and out-of-range registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 16-bit core ----------------
    logic        rst_n;
    logic        run;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        halted;
    logic [2:0]  state;
    logic [3:0]  opcode;
    logic [15:0] imem [256];

    cpu_core_if #(.WORD_SIZE(16)) bus ();

    cpu_core #(.WORD_SIZE(16), .REG_COUNT(16), .PC_WIDTH(8)) dut (
        .clk        (clk),
        .do_reset_n (rst_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .port_bus   (bus),
        .halted     (halted),
        .state      (state),
        .opcode     (opcode)
    );

    always @(posedge clk) imem_data <= imem[imem_addr];

    // ---------------- 32-bit core, 8 registers ----------------
    logic        rst32_n;
    logic        run32;
    logic [7:0]  imem32_addr;
    logic [15:0] imem32_data;
    logic        halted32;
    logic [2:0]  state32;
    logic [3:0]  opcode32;
    logic [15:0] imem32 [256];
    logic [31:0] log32_addr [$];
    logic [31:0] log32_data [$];

    cpu_core_if #(.WORD_SIZE(32)) bus32 ();

    cpu_core #(.WORD_SIZE(32), .REG_COUNT(8), .PC_WIDTH(8)) dut32 (
        .clk        (clk),
        .do_reset_n (rst32_n),
        .run        (run32),
        .imem_addr  (imem32_addr),
        .imem_data  (imem32_data),
        .port_bus   (bus32),
        .halted     (halted32),
        .state      (state32),
        .opcode     (opcode32)
    );

    always @(posedge clk) imem32_data <= imem32[imem32_addr];
    // Zero-wait slave: every request completes in its first PORT cycle.
    assign bus32.port_ack   = bus32.port_req;
    assign bus32.port_rdata = 32'd0;
    always @(negedge clk) begin
        if (bus32.port_req === 1'b1) begin
            log32_addr.push_back(bus32.port_addr);
            log32_data.push_back(bus32.port_wdata);
        end
    end

    // ---------------- checking helpers ----------------
    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    function automatic logic [15:0] ins_i(input logic [3:0] op, input logic [3:0] r,
                                          input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    // Holds reset across two clock edges; leaves rst_n released at a negedge.
    task automatic reset_core();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"},  state, 3'd0);
        check({tag, " halted"}, halted, 1'b0);
        check({tag, " opcode"}, opcode, 4'hF);
        check({tag, " pc"},     imem_addr, 8'h00);
        check({tag, " req"},    bus.port_req, 1'b0);
        check({tag, " we"},     bus.port_we, 1'b0);
        check({tag, " addr"},   bus.port_addr, 16'h0);
        check({tag, " wdata"},  bus.port_wdata, 16'h0);
    endtask

    // Waits for a request, checks it, acks after 'waits' extra PORT cycles
    // and checks how many cycles port_req stayed high. Returns at the
    // negedge following the ack edge.
    task automatic serve(input string name, input int waits, input logic [15:0] rdata,
                         input logic exp_we, input logic [15:0] exp_addr,
                         input bit chk_data, input logic [15:0] exp_data);
        bit          got;
        bit          stable;
        int          reqc;
        logic        w0;
        logic [15:0] a0;
        logic [15:0] d0;
        got = 1'b0;
        stable = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.port_req === 1'b1) got = 1'b1;
        end
        if (!got) begin
            timeout_fail({name, " req"});
            return;
        end
        w0 = bus.port_we;
        a0 = bus.port_addr;
        d0 = bus.port_wdata;
        check({name, " we"}, w0, exp_we);
        check({name, " addr"}, a0, exp_addr);
        if (chk_data) check({name, " wdata"}, d0, exp_data);
        reqc = 1;
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            if (bus.port_req === 1'b1) reqc++;
            if (bus.port_we !== w0 || bus.port_addr !== a0 || bus.port_wdata !== d0)
                stable = 1'b0;
        end
        bus.port_rdata = rdata;
        bus.port_ack   = 1'b1;
        @(negedge clk);
        bus.port_ack = 1'b0;
        if (bus.port_req === 1'b1) reqc++;
        check({name, " req cycles"}, reqc, waits + 1);
        if (waits > 0) check({name, " held stable"}, stable, 1'b1);
    endtask

    task automatic wait_halt(input string name);
        for (int t = 0; t < 200 && halted !== 1'b1; t++) @(negedge clk);
        if (halted !== 1'b1) timeout_fail({name, " halt"});
    endtask

    // ---------------- ALU vector table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        bit got;

        vecs[0]  = '{4'h0, 16'h1234, 16'h0FFF, 16'h2233};
        vecs[1]  = '{4'h0, 16'hFFFF, 16'h0002, 16'h0001};
        vecs[2]  = '{4'h1, 16'h0005, 16'h0007, 16'hFFFE};
        vecs[3]  = '{4'h2, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[4]  = '{4'h3, 16'hF0F0, 16'h0F01, 16'hFFF1};
        vecs[5]  = '{4'h4, 16'hAAAA, 16'hFFFF, 16'h5555};
        vecs[6]  = '{4'h5, 16'h0001, 16'h000F, 16'h8000};
        vecs[7]  = '{4'h5, 16'h0003, 16'h0021, 16'h0006};
        vecs[8]  = '{4'h6, 16'h8000, 16'h0004, 16'h0800};
        vecs[9]  = '{4'h6, 16'hFFFF, 16'h0010, 16'h0000};
        vecs[10] = '{4'h7, 16'hFFFF, 16'h0001, 16'h0001};
        vecs[11] = '{4'h7, 16'h0001, 16'hFFFF, 16'h0000};
        vecs[12] = '{4'h7, 16'h8000, 16'h8000, 16'h0000};

        rst_n = 1'b0; run = 1'b0;
        bus.port_ack = 1'b0; bus.port_rdata = 16'h0;
        rst32_n = 1'b0; run32 = 1'b0;
        clear_imem();
        for (int i = 0; i < 256; i++) imem32[i] = 16'hF000;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // ---- LOADLO / ADD with state sequence ----
        imem[0] = ins_i(4'h8, 4'd1, 8'h7F);
        imem[1] = ins_i(4'h8, 4'd2, 8'h80);
        imem[2] = ins(4'h0, 4'd3, 4'd1, 4'd2);
        imem[3] = ins(4'hB, 4'd2, 4'd0, 4'd0);
        imem[4] = ins(4'hB, 4'd3, 4'd0, 4'd1);
        imem[5] = 16'hE000;
        run = 1'b1;
        rst_n = 1'b1;
        check("seq state 0", state, 3'd0);
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("seq state %0d", k), state, 3'(k % 3));
        end
        serve("r2 sext", 0, 16'h0, 1'b1, 16'h0, 1'b1, 16'hFF80);
        serve("r3 add",  0, 16'h0, 1'b1, 16'h1, 1'b1, 16'hFFFF);
        wait_halt("seq");
        check("halt state", state, 3'd4);
        check("halt opcode", opcode, 4'hE);
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            @(negedge clk);
            check($sformatf("halted run toggle %0d", i), {halted, state, imem_addr},
                  {1'b1, 3'd4, 8'h05});
        end

        // ---- ALU vectors ----
        for (int i = 0; i < 13; i++) begin
            rst_n = 1'b0;
            run = 1'b1;
            clear_imem();
            imem[0] = ins_i(4'h8, 4'd2, vecs[i].a[15:8]);
            imem[1] = ins_i(4'h9, 4'd2, vecs[i].a[7:0]);
            imem[2] = ins_i(4'h8, 4'd3, vecs[i].b[15:8]);
            imem[3] = ins_i(4'h9, 4'd3, vecs[i].b[7:0]);
            imem[4] = ins(vecs[i].op, 4'd1, 4'd2, 4'd3);
            imem[5] = ins(4'hB, 4'd1, 4'd0, 4'd7);
            imem[6] = 16'hE000;
            reset_core();
            serve($sformatf("alu vec %0d", i), 0, 16'h0, 1'b1, 16'h7, 1'b1, vecs[i].exp);
            wait_halt($sformatf("alu vec %0d", i));
        end

        // ---- OUT with four wait cycles ----
        rst_n = 1'b0;
        clear_imem();
        imem[0] = ins_i(4'h8, 4'd1, 8'hBE);
        imem[1] = ins_i(4'h9, 4'd1, 8'hEF);
        imem[2] = ins_i(4'h8, 4'd2, 8'h10);
        imem[3] = ins(4'hB, 4'd1, 4'd2, 4'd3);
        imem[4] = 16'hE000;
        reset_core();
        serve("out wait", 4, 16'h0, 1'b1, 16'h0013, 1'b1, 16'hBEEF);
        check("out pc after", imem_addr, 8'h04);
        wait_halt("out wait");

        // ---- IN, zero-wait ack, then reset during PORT ----
        rst_n = 1'b0;
        clear_imem();
        imem[0] = ins(4'hB, 4'd4, 4'd0, 4'd1);
        imem[1] = ins(4'hA, 4'd4, 4'd0, 4'd0);
        imem[2] = ins(4'hB, 4'd4, 4'd0, 4'd2);
        imem[3] = 16'hE000;
        reset_core();
        serve("in pre", 0, 16'h0, 1'b1, 16'h1, 1'b1, 16'h0000);
        c0 = cyc;
        serve("in", 0, 16'hA5A5, 1'b0, 16'h0, 1'b0, 16'h0);
        c1 = cyc;
        check("in latency", c1 - c0, 4);
        check("in pc after", imem_addr, 8'h02);
        serve("in result", 0, 16'h0, 1'b1, 16'h2, 1'b1, 16'hA5A5);
        wait_halt("in");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("reset from halt");
        serve("r4 cleared", 0, 16'h0, 1'b1, 16'h1, 1'b1, 16'h0000);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.port_req === 1'b1) got = 1'b1;
        end
        if (!got) timeout_fail("in reset req");
        repeat (2) @(negedge clk);
        check("in waiting req", bus.port_req, 1'b1);
        bus.port_rdata = 16'h1234;
        bus.port_ack   = 1'b1;
        rst_n          = 1'b0;
        @(negedge clk);
        check("reset mid port req", bus.port_req, 1'b0);
        check("reset mid port state", state, 3'd0);
        bus.port_ack = 1'b0;
        rst_n        = 1'b1;
        serve("in discarded", 0, 16'h0, 1'b1, 16'h1, 1'b1, 16'h0000);

        // ---- BR countdown loop ----
        rst_n = 1'b0;
        clear_imem();
        imem[0] = ins_i(4'h8, 4'd1, 8'h03);
        imem[1] = ins_i(4'h8, 4'd2, 8'h01);
        imem[2] = ins(4'hB, 4'd1, 4'd0, 4'd5);
        imem[3] = ins(4'h1, 4'd1, 4'd1, 4'd2);
        imem[4] = ins_i(4'hD, 4'd1, 8'hFE);
        imem[5] = ins(4'hB, 4'd1, 4'd0, 4'd6);
        imem[6] = 16'hE000;
        reset_core();
        for (int k = 3; k >= 1; k--) begin
            serve($sformatf("br body %0d", k), 0, 16'h0, 1'b1, 16'h5, 1'b1, 16'(k));
        end
        serve("br exit", 0, 16'h0, 1'b1, 16'h6, 1'b1, 16'h0000);
        check("br exit pc", imem_addr, 8'h06);
        wait_halt("br");
        check("br halt pc", imem_addr, 8'h06);

        // ---- JMP -1 wrap with run gating ----
        rst_n = 1'b0;
        run = 1'b0;
        clear_imem();
        imem[0]   = ins_i(4'hC, 4'd0, 8'hFF);
        imem[255] = 16'hE000;
        reset_core();
        repeat (4) @(negedge clk);
        check("run low state", state, 3'd0);
        check("run low pc", imem_addr, 8'h00);
        run = 1'b1;
        @(negedge clk);
        check("run decode", state, 3'd1);
        run = 1'b0;
        @(negedge clk);
        check("run low exec", state, 3'd2);
        @(negedge clk);
        check("jmp wrap pc", imem_addr, 8'hFF);
        repeat (2) @(negedge clk);
        check("run low parked", state, 3'd0);
        run = 1'b1;
        wait_halt("jmp");
        check("jmp halt pc", imem_addr, 8'hFF);

        // ---- 32-bit core: wide constants, same-register add, bad index ----
        imem32[0]  = ins_i(4'h8, 4'd1, 8'h12);
        imem32[1]  = ins_i(4'h9, 4'd1, 8'h34);
        imem32[2]  = ins_i(4'h9, 4'd1, 8'h56);
        imem32[3]  = ins_i(4'h9, 4'd1, 8'h78);
        imem32[4]  = ins(4'hB, 4'd1, 4'd0, 4'd0);
        imem32[5]  = ins(4'h0, 4'd1, 4'd1, 4'd1);
        imem32[6]  = ins(4'hB, 4'd1, 4'd0, 4'd1);
        imem32[7]  = ins_i(4'h8, 4'd9, 8'h55);
        imem32[8]  = ins(4'hB, 4'd9, 4'd0, 4'd2);
        imem32[9]  = ins_i(4'h8, 4'd2, 8'h80);
        imem32[10] = ins(4'hB, 4'd2, 4'd0, 4'd3);
        imem32[11] = 16'hE000;
        repeat (2) @(negedge clk);
        rst32_n = 1'b1;
        run32 = 1'b1;
        for (int t = 0; t < 300 && halted32 !== 1'b1; t++) @(negedge clk);
        if (halted32 !== 1'b1) timeout_fail("w32 halt");
        check("w32 out count", log32_data.size(), 4);
        if (log32_data.size() == 4) begin
            check("w32 addr0", log32_addr[0], 32'h0);
            check("w32 loadhi", log32_data[0], 32'h12345678);
            check("w32 add self", log32_data[1], 32'h2468ACF0);
            check("w32 bad reg", log32_data[2], 32'h0);
            check("w32 addr3", log32_addr[3], 32'h3);
            check("w32 sext", log32_data[3], 32'hFFFFFF80);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
